imm_gen_unit: RTL and testbench



---
 rtl/vcpu32_pkg.sv | 25 ++
 rtl/imm_gen_unit_if.sv | 24 ++
 rtl/imm_gen_unit_extract.sv | 35 +++
 rtl/imm_gen_unit.sv | 33 +++
 tb/tb_imm_gen_unit.sv | 124 ++++++++++++
 5 files changed

// File: rtl/vcpu32_pkg.sv
// rtl/vcpu32_pkg.sv - VCPU-32 opcode, group-mask, field-position and mode constants
package vcpu32_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_LDIL     = 6'h01;
    localparam logic [5:0] OP_ADDIL    = 6'h02;
    localparam logic [5:0] OP_ALU_BASE = 6'h10;
    localparam logic [5:0] OP_MEM_BASE = 6'h20;
    localparam logic [5:0] OP_B        = 6'h30;
    localparam logic [5:0] OP_BL       = 6'h31;

    // ALU and memory groups each span eight consecutive opcodes
    localparam logic [5:0] GRP_MASK    = 6'h38;

    // Field positions use MSB-first numbering (bit 0 is the MSB)
    localparam int OPC_HI  = 0;
    localparam int OPC_LO  = 5;
    localparam int MODE_HI = 12;
    localparam int MODE_LO = 13;
    localparam int SIGN_BIT = 31;

    localparam logic [1:0] MODE_IMM = 2'b00;

endpackage

// File: rtl/imm_gen_unit_if.sv
// rtl/imm_gen_unit_if.sv - instruction-in / immediate-out bundle for the immediate generator
interface imm_gen_unit_if;
    import vcpu32_pkg::*;

    logic [0:WORD_W-1] instr;
    logic              instr_valid;
    logic [0:WORD_W-1] y;
    logic              y_valid;

    modport master (
        output instr,
        output instr_valid,
        input  y,
        input  y_valid
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output y,
        output y_valid
    );

endinterface

// File: rtl/imm_gen_unit_extract.sv
// rtl/imm_gen_unit_extract.sv - combinational instruction-word to immediate formatter
module imm_extract
    import vcpu32_pkg::*;
(
    input  logic [0:WORD_W-1] instr,
    output logic [0:WORD_W-1] imm
);

    logic [5:0] opcode;
    logic [1:0] mode;
    logic       sgn;
    logic       unused_bits;

    assign opcode      = instr[OPC_HI:OPC_LO];
    assign mode        = instr[MODE_HI:MODE_LO];
    assign sgn         = instr[SIGN_BIT];
    assign unused_bits = ^instr[6:9];

    // Sign bit sits at the right end of each signed field
    always_comb begin
        imm = '0;
        if (opcode == OP_LDIL || opcode == OP_ADDIL) begin
            imm = {instr[10:31], 10'b0};
        end else if ((opcode & GRP_MASK) == OP_ALU_BASE) begin
            if (mode == MODE_IMM) begin
                imm = {{15{sgn}}, instr[14:30]};
            end
        end else if ((opcode & GRP_MASK) == OP_MEM_BASE) begin
            imm = {{21{sgn}}, instr[20:30]};
        end else if (opcode == OP_B || opcode == OP_BL) begin
            imm = {{9{sgn}}, instr[10:30], 2'b00};
        end
    end

endmodule

// File: rtl/imm_gen_unit.sv
// rtl/imm_gen_unit.sv - registered immediate generator for the decode stage
module imm_gen_unit
    import vcpu32_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_unit_if.slave  bus
);

    logic [0:WORD_W-1] y_d;
    logic [0:WORD_W-1] y_q;
    logic              y_valid_q;

    imm_extract u_extract (
        .instr (bus.instr),
        .imm   (y_d)
    );

    // y follows every cycle; y_valid is the only qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= bus.instr_valid;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_imm_gen_unit.sv
// tb/tb_imm_gen_unit.sv - self-checking bench for imm_gen_unit
module tb_imm_gen_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    imm_gen_unit_if bus ();

    imm_gen_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int unsigned op, mode, s, f;
        op   = w >> 26;
        mode = (w >> 18) & 3;
        s    = w & 1;
        if (op == 1 || op == 2) return (w & 32'h003F_FFFF) << 10;
        if (op >= 16 && op <= 23) begin
            if (mode != 0) return 0;
            f = (w >> 1) & 32'h1FFFF;
            return s ? (f | ~32'h1FFFF) : f;
        end
        if (op >= 32 && op <= 39) begin
            f = (w >> 1) & 32'h7FF;
            return s ? (f | ~32'h7FF) : f;
        end
        if (op == 48 || op == 49) begin
            f = ((w >> 1) & 32'h1F_FFFF) << 2;
            return s ? (f | ~32'h7F_FFFF) : f;
        end
        return 0;
    endfunction

    task automatic step(input logic [31:0] w, input logic v, input string tag);
        @(negedge clk);
        bus.instr       = w;
        bus.instr_valid = v;
        @(posedge clk);
        #1;
        check_eq({tag, ".y"}, bus.y, ref_imm(w));
        check_eq({tag, ".vld"}, {31'd0, bus.y_valid}, {31'd0, v});
    endtask

    logic [31:0] dir_instr [10];
    logic [31:0] dir_exp   [10];
    logic [5:0]  ops       [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        dir_instr = '{32'h04000001, 32'h40000003, 32'h40080003, 32'h80000FFE, 32'h80000001,
                      32'hC0000003, 32'hC4000002, 32'h00000000, 32'h08000000, 32'h5C000000};
        dir_exp   = '{32'h00000400, 32'hFFFE0001, 32'h00000000, 32'h000007FF, 32'hFFFFF800,
                      32'hFF800004, 32'h00000004, 32'h00000000, 32'h00000000, 32'h00000000};
        ops = '{6'h01, 6'h02, 6'h10, 6'h17, 6'h18, 6'h20, 6'h27, 6'h28, 6'h30, 6'h31, 6'h32, 6'h0F};

        rst_n = 1'b0;
        bus.instr = 32'hFFFFFFFF;
        bus.instr_valid = 1'b1;
        #1;
        check_eq("rst.y", bus.y, 32'h0);
        check_eq("rst.vld", {31'd0, bus.y_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold.y", bus.y, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'hFFFFFFFF, 1'b1, "post_rst");

        for (int i = 0; i < 10; i++) begin
            step(dir_instr[i], 1'b1, $sformatf("dir%0d", i));
            check_eq($sformatf("dir%0d.tbl", i), bus.y, dir_exp[i]);
        end

        // back-to-back with valid toggling
        step(32'h04000001, 1'b0, "b2b_ldil");
        step(32'h40000003, 1'b1, "b2b_alu");
        step(32'hC0000003, 1'b0, "b2b_br");
        step(32'h80000001, 1'b1, "b2b_mem");

        // mid-stream asynchronous reset discards the in-flight result
        @(negedge clk);
        bus.instr = 32'hC0000003;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst.y", bus.y, 32'h0);
        check_eq("mid_rst.vld", {31'd0, bus.y_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h40000003, 1'b1, "after_mid_rst");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (i % 4 != 3) w = {ops[$urandom_range(0, 11)], w[25:0]};
            if ($urandom_range(0, 3) == 0) w[19:18] = 2'b00;
            step(w, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
